// File: rtl/sgf_norm_round_fsm_pkg.sv
// Shared definitions for the FP multiplier significand path: rounding-mode codes and
// the normalise/round FSM state encoding.
package sgf_norm_round_fsm_pkg;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RDN = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_NORM   = 3'd1,
        ST_ROUND  = 3'd2,
        ST_RENORM = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/sgf_norm_round_fsm_if.sv
// Valid/ready link between the significand product stage and the normalise/round stage,
// and from that stage on to the exponent/pack stage.
interface sgf_norm_round_fsm_if #(parameter int W_Sgf = 23);
    logic               in_valid;
    logic               in_ready;
    logic [W_Sgf+1:0]   sgf_in;
    logic               guard_in;
    logic               sticky_in;
    logic               sign_in;
    logic [1:0]         rmode_in;
    logic               out_valid;
    logic               out_ready;
    logic [W_Sgf:0]     sgf_out;
    logic [1:0]         exp_inc;
    logic               inexact;

    modport master (
        output in_valid, sgf_in, guard_in, sticky_in, sign_in, rmode_in, out_ready,
        input  in_ready, out_valid, sgf_out, exp_inc, inexact
    );

    modport slave (
        input  in_valid, sgf_in, guard_in, sticky_in, sign_in, rmode_in, out_ready,
        output in_ready, out_valid, sgf_out, exp_inc, inexact
    );
endinterface

// File: rtl/sgf_norm_round_fsm_round_decide.sv
// Rounding increment decision; purely combinational so the adder path can share it.
module fp_round_decide
    import sgf_norm_round_fsm_pkg::*;
(
    input  logic [1:0] rmode,
    input  logic       sign,
    input  logic       lsb,
    input  logic       g,
    input  logic       s,
    output logic       inc
);
    always_comb begin
        inc = 1'b0;
        case (rmode)
            RM_RNE:  inc = g & (s | lsb);
            RM_RTZ:  inc = 1'b0;
            RM_RUP:  inc = ~sign & (g | s);
            RM_RDN:  inc = sign & (g | s);
            default: inc = 1'b0;
        endcase
    end
endmodule

// File: rtl/sgf_norm_round_fsm.sv
// Sequential normalise -> round -> re-normalise of the multiplier product significand,
// producing the final significand, an exponent increment and the inexact flag.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for an operand, in_ready=1
// ST_NORM   | drop the carry bit if set (shift right into guard/sticky)
// ST_ROUND  | apply the rounding increment, detect round overflow
// ST_RENORM | round overflowed: result is 1.000..0, bump exponent again
// ST_DONE   | result presented, held until out_ready
module sgf_norm_round_fsm
    import sgf_norm_round_fsm_pkg::*;
#(
    parameter int W_Sgf = 23
)(
    input  logic               clk,
    input  logic               rst,
    sgf_norm_round_fsm_if.slave bus
);
    state_e           state;
    logic [W_Sgf+1:0] sgf_q;
    logic             g_q;
    logic             s_q;
    logic             sign_q;
    logic [1:0]       rmode_q;
    logic [W_Sgf:0]   mant_q;
    logic [W_Sgf:0]   sum_hi_q;
    logic             out_valid_q;
    logic [W_Sgf:0]   sgf_out_q;
    logic [1:0]       exp_inc_q;
    logic             inexact_q;

    logic             inc;
    logic [W_Sgf+1:0] sum;

    fp_round_decide u_round_decide (
        .rmode (rmode_q),
        .sign  (sign_q),
        .lsb   (mant_q[0]),
        .g     (g_q),
        .s     (s_q),
        .inc   (inc)
    );

    assign sum = {1'b0, mant_q} + {{(W_Sgf+1){1'b0}}, inc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            sgf_q       <= '0;
            g_q         <= 1'b0;
            s_q         <= 1'b0;
            sign_q      <= 1'b0;
            rmode_q     <= RM_RNE;
            mant_q      <= '0;
            sum_hi_q    <= '0;
            out_valid_q <= 1'b0;
            sgf_out_q   <= '0;
            exp_inc_q   <= 2'd0;
            inexact_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        sgf_q     <= bus.sgf_in;
                        g_q       <= bus.guard_in;
                        s_q       <= bus.sticky_in;
                        sign_q    <= bus.sign_in;
                        rmode_q   <= bus.rmode_in;
                        exp_inc_q <= 2'd0;
                        // An exact zero needs no normalising or rounding.
                        if (bus.sgf_in == '0 && !bus.guard_in && !bus.sticky_in) begin
                            sgf_out_q   <= '0;
                            inexact_q   <= 1'b0;
                            out_valid_q <= 1'b1;
                            state       <= ST_DONE;
                        end else begin
                            state <= ST_NORM;
                        end
                    end
                end
                ST_NORM: begin
                    if (sgf_q[W_Sgf+1]) begin
                        mant_q    <= sgf_q[W_Sgf+1:1];
                        g_q       <= sgf_q[0];
                        s_q       <= s_q | g_q;
                        exp_inc_q <= 2'd1;
                    end else begin
                        mant_q    <= sgf_q[W_Sgf:0];
                        exp_inc_q <= 2'd0;
                    end
                    state <= ST_ROUND;
                end
                ST_ROUND: begin
                    inexact_q <= g_q | s_q;
                    sum_hi_q  <= sum[W_Sgf+1:1];
                    if (sum[W_Sgf+1]) begin
                        state <= ST_RENORM;
                    end else begin
                        sgf_out_q   <= sum[W_Sgf:0];
                        out_valid_q <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_RENORM: begin
                    sgf_out_q   <= sum_hi_q;
                    exp_inc_q   <= exp_inc_q + 2'd1;
                    out_valid_q <= 1'b1;
                    state       <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.sgf_out   = sgf_out_q;
    assign bus.exp_inc   = exp_inc_q;
    assign bus.inexact   = inexact_q;
endmodule

// File: tb/tb_sgf_norm_round_fsm.sv
// Directed bench for the significand normalise/round stage (single precision).
module tb_sgf_norm_round_fsm;
    import sgf_norm_round_fsm_pkg::*;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   hs_cnt = 0;
    int   lat;

    sgf_norm_round_fsm_if #(.W_Sgf(23)) bus ();

    sgf_norm_round_fsm #(.W_Sgf(23)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) hs_cnt <= hs_cnt + 1;
    end

    typedef struct {
        logic [1:0]  rm;
        logic        sign;
        logic [24:0] sgf;
        logic        g;
        logic        s;
        logic [23:0] e_sgf;
        logic [1:0]  e_inc;
        logic        e_inx;
        int          e_lat;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic issue(input vec_t v, input string tag);
        @(negedge clk);
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.rmode_in  = v.rm;
        bus.sign_in   = v.sign;
        bus.sgf_in    = v.sgf;
        bus.guard_in  = v.g;
        bus.sticky_in = v.s;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_result(input vec_t v, input string tag);
        chk({tag, ".latency"}, 32'(lat), 32'(v.e_lat));
        chk({tag, ".sgf_out"}, 32'(bus.sgf_out), 32'(v.e_sgf));
        chk({tag, ".exp_inc"}, 32'(bus.exp_inc), 32'(v.e_inc));
        chk({tag, ".inexact"}, 32'(bus.inexact), 32'(v.e_inx));
    endtask

    task automatic take(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, ".out_valid_drop"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".in_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        //           rm      sign sgf          g     s      e_sgf        inc   inx   lat
        vecs[0]  = '{RM_RNE, 1'b0, 25'h0800000, 1'b0, 1'b0, 24'h800000, 2'd0, 1'b0, 3};
        vecs[1]  = '{RM_RNE, 1'b0, 25'h1800001, 1'b0, 1'b0, 24'hC00000, 2'd1, 1'b1, 3};
        vecs[2]  = '{RM_RNE, 1'b0, 25'h0FFFFFF, 1'b1, 1'b1, 24'h800000, 2'd1, 1'b1, 4};
        vecs[3]  = '{RM_RTZ, 1'b1, 25'h0800001, 1'b1, 1'b0, 24'h800001, 2'd0, 1'b1, 3};
        vecs[4]  = '{RM_RUP, 1'b1, 25'h0800001, 1'b1, 1'b0, 24'h800001, 2'd0, 1'b1, 3};
        vecs[5]  = '{RM_RDN, 1'b1, 25'h0800001, 1'b1, 1'b0, 24'h800002, 2'd0, 1'b1, 3};
        vecs[6]  = '{RM_RNE, 1'b1, 25'h0800001, 1'b1, 1'b0, 24'h800002, 2'd0, 1'b1, 3};
        vecs[7]  = '{RM_RNE, 1'b0, 25'h1FFFFFF, 1'b1, 1'b0, 24'h800000, 2'd2, 1'b1, 4};
        vecs[8]  = '{RM_RNE, 1'b0, 25'h0800000, 1'b1, 1'b0, 24'h800000, 2'd0, 1'b1, 3};
        vecs[9]  = '{RM_RUP, 1'b0, 25'h0800000, 1'b0, 1'b1, 24'h800001, 2'd0, 1'b1, 3};
        vecs[10] = '{RM_RDN, 1'b0, 25'h0800000, 1'b0, 1'b1, 24'h800000, 2'd0, 1'b1, 3};
        vecs[11] = '{RM_RUP, 1'b0, 25'h0000000, 1'b1, 1'b0, 24'h000001, 2'd0, 1'b1, 3};
        vecs[12] = '{RM_RTZ, 1'b0, 25'h0000000, 1'b0, 1'b0, 24'h000000, 2'd0, 1'b0, 1};
        vecs[13] = '{RM_RTZ, 1'b0, 25'h1FFFFFF, 1'b1, 1'b1, 24'hFFFFFF, 2'd1, 1'b1, 3};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.sgf_in    = '0;
        bus.guard_in  = 1'b0;
        bus.sticky_in = 1'b0;
        bus.sign_in   = 1'b0;
        bus.rmode_in  = RM_RNE;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset.sgf_out",   32'(bus.sgf_out),   32'd0);
        chk("reset.exp_inc",   32'(bus.exp_inc),   32'd0);
        chk("reset.inexact",   32'(bus.inexact),   32'd0);
        chk("reset.in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            issue(vecs[i], tag);
            check_result(vecs[i], tag);
            take(tag);
        end

        // Back-pressure: hold the result for 10 cycles, then exactly one handshake.
        issue(vecs[0], "bp");
        check_result(vecs[0], "bp");
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp.hold%0d.out_valid", c), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp.hold%0d.sgf_out", c),   32'(bus.sgf_out),   32'h800000);
            chk($sformatf("bp.hold%0d.in_ready", c),  32'(bus.in_ready),  32'd0);
        end
        begin
            int hs0;
            hs0 = hs_cnt;
            @(negedge clk);
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            chk("bp.release.out_valid", 32'(bus.out_valid), 32'd0);
            chk("bp.release.in_ready",  32'(bus.in_ready),  32'd1);
            chk("bp.release.sgf_hold",  32'(bus.sgf_out),   32'h800000);
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            chk("bp.handshakes", 32'(hs_cnt - hs0), 32'd1);
        end
        issue(vecs[12], "bp_zero");
        check_result(vecs[12], "bp_zero");
        take("bp_zero");

        // Reset while in ROUND, with non-zero outputs left from the previous result.
        issue(vecs[1], "pre_rst");
        check_result(vecs[1], "pre_rst");
        take("pre_rst");
        @(negedge clk);
        bus.rmode_in  = vecs[7].rm;
        bus.sign_in   = vecs[7].sign;
        bus.sgf_in    = vecs[7].sgf;
        bus.guard_in  = vecs[7].g;
        bus.sticky_in = vecs[7].s;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid.exp_inc_before_rst", 32'(bus.exp_inc), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mid.sgf_out",   32'(bus.sgf_out),   32'd0);
        chk("rst_mid.exp_inc",   32'(bus.exp_inc),   32'd0);
        chk("rst_mid.inexact",   32'(bus.inexact),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid.in_ready", 32'(bus.in_ready), 32'd1);
        issue(vecs[2], "post_rst");
        check_result(vecs[2], "post_rst");
        take("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
